// File: rtl/wb_arbiter2.sv
// rtl/wb_arbiter2.sv - two-master round-robin Wishbone arbiter with per-access watchdog
module wb_arbiter2 #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [25:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic        m0_we_i,
    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    input  logic        m0_tagn_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic [25:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic        m1_we_i,
    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    input  logic        m1_tagn_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [25:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic        s_we_o,
    output logic        s_stb_o,
    output logic        s_cyc_o,
    output logic        s_tagn_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    output logic [1:0]  gnt_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN0 = 2'd1,
        S_OWN1 = 2'd2
    } state_t;

    // Watchdog fires on the cycle where the counter already holds TIMEOUT-1
    // and the strobe is still waiting, i.e. the TIMEOUT-th waiting cycle.
    localparam logic [CNT_W-1:0] LIM = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_last;        // 0: m0 owned last, 1: m1 owned last
    logic [CNT_W-1:0] r_cnt;
    logic             w_own_stb;
    logic             w_limit;

    assign w_own_stb = ((r_state == S_OWN0) && m0_stb_i) ||
                       ((r_state == S_OWN1) && m1_stb_i);
    assign w_limit   = (TIMEOUT != 0) && w_own_stb && (r_cnt == LIM);

    // Read data is broadcast; only the ack qualifies it.
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    // State register and last-owner pointer, updated on every entry to OWNn
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_IDLE && w_state_next == S_OWN0) begin
                r_last <= 1'b0;
            end else if (r_state == S_IDLE && w_state_next == S_OWN1) begin
                r_last <= 1'b1;
            end
        end
    end

    // Next-state: grant from IDLE only, so handovers always pass through IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    w_state_next = r_last ? S_OWN0 : S_OWN1;
                end else if (m0_cyc_i) begin
                    w_state_next = S_OWN0;
                end else if (m1_cyc_i) begin
                    w_state_next = S_OWN1;
                end
            end
            S_OWN0:  if (!m0_cyc_i) w_state_next = S_IDLE;
            S_OWN1:  if (!m1_cyc_i) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Watchdog counts waiting strobe cycles; any ack, idle strobe, expiry or ownership change clears it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (r_state == S_IDLE || w_state_next != r_state ||
                     !w_own_stb || s_ack_i || w_limit) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Output mux: owner drives the slave, ack/err routed back to the owner only
    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_we_o   = 1'b0;
        s_stb_o  = 1'b0;
        s_cyc_o  = 1'b0;
        s_tagn_o = 1'b0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        gnt_o    = 2'b00;
        case (r_state)
            S_OWN0: begin
                gnt_o    = 2'b01;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_we_o   = m0_we_i;
                s_stb_o  = m0_stb_i && !w_limit;
                s_cyc_o  = m0_cyc_i;
                s_tagn_o = m0_tagn_i;
                m0_ack_o = s_ack_i;
                m0_err_o = w_limit && !s_ack_i;
            end
            S_OWN1: begin
                gnt_o    = 2'b10;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_we_o   = m1_we_i;
                s_stb_o  = m1_stb_i && !w_limit;
                s_cyc_o  = m1_cyc_i;
                s_tagn_o = m1_tagn_i;
                m1_ack_o = s_ack_i;
                m1_err_o = w_limit && !s_ack_i;
            end
            default: ;
        endcase
    end

endmodule
